ex_muldiv_iter: RTL and testbench

Parametrised iterative multiply/divide unit for the EX stage. It executes MULT, MULTU, DIV and DIVU and produces a double-width HI/LO result. The multiplier retires a configurable number of bits per cycle; the divider is restoring, at one bit per cycle. It uses the stall-request handshake already used by the pipeline control (EX holds the request high while stalled) and supports flush cancellation and divide-by-zero detection.

---
 rtl/ex_muldiv_iter.sv | 218 +++++++++++++++++++++
 tb/tb_ex_muldiv_iter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage: radix-2^MUL_STEP shift-add
// multiplier, restoring divider, sign fix-up cycle and a one-cycle done pulse.
module ex_muldiv_iter #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             stallreq_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);

  localparam int DW      = 2 * WIDTH;
  localparam int CNT_W   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int MUL_CYC = WIDTH / MUL_STEP;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    neg_w = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [DW-1:0] neg_dw(input logic [DW-1:0] v);
    neg_dw = ~v + {{(DW-1){1'b0}}, 1'b1};
  endfunction

  state_t             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   a_mag_q, a_mag_d;
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dbz_q, dbz_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               dbz_out_q, dbz_out_d;

  logic                      sign_a_s, sign_b_s;
  logic [WIDTH-1:0]          a_abs_s, b_abs_s;
  logic [WIDTH+MUL_STEP-1:0] pp_s, mul_sum_s;
  logic [DW-1:0]             mul_next_s;
  logic [WIDTH:0]            div_trial_s;
  logic [DW-1:0]             div_next_s;
  logic [DW-1:0]             prod_fix_s;
  logic [WIDTH-1:0]          quo_fix_s, rem_fix_s;

  // Datapath: operand magnitudes, one multiply/divide step, sign fix-up
  always_comb begin
    sign_a_s = op_i[0] & a_i[WIDTH-1];
    sign_b_s = op_i[0] & b_i[WIDTH-1];
    a_abs_s  = sign_a_s ? neg_w(a_i) : a_i;
    b_abs_s  = sign_b_s ? neg_w(b_i) : b_i;

    // Low half of acc holds the unconsumed multiplier digits
    pp_s       = {{MUL_STEP{1'b0}}, a_mag_q} * {{WIDTH{1'b0}}, acc_q[MUL_STEP-1:0]};
    mul_sum_s  = {{MUL_STEP{1'b0}}, acc_q[DW-1:WIDTH]} + pp_s;
    mul_next_s = {mul_sum_s, acc_q[WIDTH-1:MUL_STEP]};

    // acc = {remainder, dividend/quotient}; trial subtract on the shifted remainder
    div_trial_s = acc_q[DW-1:WIDTH-1] - {1'b0, b_mag_q};
    if (!div_trial_s[WIDTH]) begin
      div_next_s = {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {acc_q[DW-2:0], 1'b0};
    end

    prod_fix_s = neg_res_q ? neg_dw(acc_q) : acc_q;
    quo_fix_s  = neg_res_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rem_fix_s  = neg_rem_q ? neg_w(acc_q[DW-1:WIDTH]) : acc_q[DW-1:WIDTH];
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    a_raw_d   = a_raw_q;
    a_mag_d   = a_mag_q;
    b_mag_d   = b_mag_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_out_d = dbz_out_q;

    case (state_q)
      S_IDLE: begin
        if (start_i && !flush) begin
          is_div_d  = op_i[1];
          a_raw_d   = a_i;
          a_mag_d   = a_abs_s;
          b_mag_d   = b_abs_s;
          neg_res_d = sign_a_s ^ sign_b_s;
          neg_rem_d = sign_a_s;
          dbz_d     = op_i[1] && (b_i == {WIDTH{1'b0}});
          cnt_d     = {CNT_W{1'b0}};
          acc_d     = {{WIDTH{1'b0}}, (op_i[1] ? a_abs_s : b_abs_s)};
          dbz_out_d = 1'b0;
          if (op_i[1] && (b_i == {WIDTH{1'b0}})) begin
            state_d = S_FIX;
          end else begin
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (flush || !start_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = is_div_q ? div_next_s : mul_next_s;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == (is_div_q ? DIV_LAST : MUL_LAST)) begin
            state_d = S_FIX;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_FIX: begin
        if (flush || !start_i) begin
          state_d = S_IDLE;
        end else begin
          if (dbz_q) begin
            hi_d      = a_raw_q;
            lo_d      = {WIDTH{1'b1}};
            dbz_out_d = 1'b1;
          end else if (is_div_q) begin
            hi_d = rem_fix_s;
            lo_d = quo_fix_s;
          end else begin
            hi_d = prod_fix_s[DW-1:WIDTH];
            lo_d = prod_fix_s[WIDTH-1:0];
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      is_div_q  <= 1'b0;
      a_raw_q   <= {WIDTH{1'b0}};
      a_mag_q   <= {WIDTH{1'b0}};
      b_mag_q   <= {WIDTH{1'b0}};
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
      acc_q     <= {DW{1'b0}};
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      a_raw_q   <= a_raw_d;
      a_mag_q   <= a_mag_d;
      b_mag_q   <= b_mag_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  assign stallreq_o    = start_i & ~done_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign div_by_zero_o = dbz_out_q;

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Directed bench for ex_muldiv_iter: vector table on the default instance plus
// flush/abort/back-to-back/reset sequences and a MUL_STEP sweep on extra instances.
module tb_ex_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [3:0]  start_v;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [3:0]  stall_v, busy_v, done_v, dbz_v;
  logic [31:0] hi_v [4];
  logic [31:0] lo_v [4];

  int   checks = 0;
  int   errors = 0;
  int   lat;
  logic sok;
  logic seen;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs [13];

  always #5 clk = ~clk;

  // index 0: MUL_STEP 2, 1: MUL_STEP 1, 2: MUL_STEP 4, 3: MUL_STEP 8
  ex_muldiv_iter #(.WIDTH(32), .MUL_STEP(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start_i(start_v[0]), .op_i(op), .a_i(a), .b_i(b),
    .stallreq_o(stall_v[0]), .busy_o(busy_v[0]), .done_o(done_v[0]),
    .hi_o(hi_v[0]), .lo_o(lo_v[0]), .div_by_zero_o(dbz_v[0]));
  ex_muldiv_iter #(.WIDTH(32), .MUL_STEP(1)) dut_s1 (
    .clk(clk), .rst(rst), .flush(flush), .start_i(start_v[1]), .op_i(op), .a_i(a), .b_i(b),
    .stallreq_o(stall_v[1]), .busy_o(busy_v[1]), .done_o(done_v[1]),
    .hi_o(hi_v[1]), .lo_o(lo_v[1]), .div_by_zero_o(dbz_v[1]));
  ex_muldiv_iter #(.WIDTH(32), .MUL_STEP(4)) dut_s4 (
    .clk(clk), .rst(rst), .flush(flush), .start_i(start_v[2]), .op_i(op), .a_i(a), .b_i(b),
    .stallreq_o(stall_v[2]), .busy_o(busy_v[2]), .done_o(done_v[2]),
    .hi_o(hi_v[2]), .lo_o(lo_v[2]), .div_by_zero_o(dbz_v[2]));
  ex_muldiv_iter #(.WIDTH(32), .MUL_STEP(8)) dut_s8 (
    .clk(clk), .rst(rst), .flush(flush), .start_i(start_v[3]), .op_i(op), .a_i(a), .b_i(b),
    .stallreq_o(stall_v[3]), .busy_o(busy_v[3]), .done_o(done_v[3]),
    .hi_o(hi_v[3]), .lo_o(lo_v[3]), .div_by_zero_o(dbz_v[3]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycle 0 is the cycle start_i is first driven; returns the cycle done_o is seen (-1 on timeout)
  task automatic run_op(input int sel, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, output int l, output logic stall_ok);
    l = -1;
    stall_ok = 1'b1;
    @(negedge clk);
    op = o; a = av; b = bv;
    start_v[sel] = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      #1;
      if (done_v[sel] === 1'b1) begin
        if (stall_v[sel] !== 1'b0) stall_ok = 1'b0;
        l = cyc;
        break;
      end
      if (stall_v[sel] !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
      if (cyc == 0) begin
        a = ~av; b = bv + 32'd1; op = ~o;
      end
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    start_v = 4'b0000;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ms_lat [3];
    ms_lat[0] = 34; ms_lat[1] = 10; ms_lat[2] = 6;

    //           op     a             b             hi            lo            dbz   lat
    vecs[0]  = '{2'b01, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 18};
    vecs[1]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 18};
    vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    vecs[3]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
    vecs[4]  = '{2'b10, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1, 2};
    vecs[5]  = '{2'b10, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 34};
    vecs[6]  = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
    vecs[7]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 18};
    vecs[8]  = '{2'b01, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0, 18};
    vecs[9]  = '{2'b00, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0, 18};
    vecs[10] = '{2'b11, 32'hFFFFFFFD, 32'd0,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b1, 2};
    vecs[11] = '{2'b10, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0, 34};
    vecs[12] = '{2'b01, 32'd0,        32'hFFFFFFFB, 32'h00000000, 32'h00000000, 1'b0, 18};

    rst = 1'b1; flush = 1'b0; start_v = 4'b0000; op = 2'b00; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_hi",   64'(hi_v[0]), 64'd0);
    check("reset_lo",   64'(lo_v[0]), 64'd0);
    check("reset_done", 64'(done_v[0]), 64'd0);
    check("reset_busy", 64'(busy_v[0]), 64'd0);
    check("reset_dbz",  64'(dbz_v[0]), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op(0, vecs[i].op, vecs[i].a, vecs[i].b, lat, sok);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d_hi", i),      64'(hi_v[0]), 64'(vecs[i].hi));
      check($sformatf("vec%0d_lo", i),      64'(lo_v[0]), 64'(vecs[i].lo));
      check($sformatf("vec%0d_dbz", i),     64'(dbz_v[0]), 64'(vecs[i].dbz));
      check($sformatf("vec%0d_stallreq", i), 64'(sok), 64'd1);
      go_idle();
    end

    // Flush in cycle 5 of a MULT: no done, prior result retained
    run_op(0, 2'b01, 32'hFFFFFFFE, 32'd3, lat, sok);
    go_idle();
    @(negedge clk);
    op = 2'b01; a = 32'h00001234; b = 32'h00005678; start_v[0] = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("flush_busy_c5", 64'(busy_v[0]), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    #1;
    check("flush_busy_c6", 64'(busy_v[0]), 64'd0);
    flush = 1'b0; start_v[0] = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (done_v[0] === 1'b1) seen = 1'b1;
    end
    check("flush_no_done", 64'(seen), 64'd0);
    check("flush_hi_kept", 64'(hi_v[0]), 64'hFFFFFFFF);
    check("flush_lo_kept", 64'(lo_v[0]), 64'hFFFFFFFA);

    // start_i dropping mid-CALC aborts like a flush
    @(negedge clk);
    op = 2'b10; a = 32'd100; b = 32'd7; start_v[0] = 1'b1;
    repeat (3) @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    #1;
    check("abort_busy", 64'(busy_v[0]), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (done_v[0] === 1'b1) seen = 1'b1;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    check("abort_lo_kept", 64'(lo_v[0]), 64'hFFFFFFFA);

    // Flush together with start in IDLE: no accept
    @(negedge clk);
    op = 2'b01; a = 32'd3; b = 32'd3; start_v[0] = 1'b1; flush = 1'b1;
    @(negedge clk);
    #1;
    check("flush_idle_no_accept", 64'(busy_v[0]), 64'd0);
    start_v[0] = 1'b0; flush = 1'b0;

    // Back-to-back: second op issued in the cycle after done
    run_op(0, 2'b10, 32'd100, 32'd7, lat, sok);
    check("b2b_first_lo", 64'(lo_v[0]), 64'h0000000E);
    check("b2b_first_hi", 64'(hi_v[0]), 64'h00000002);
    run_op(0, 2'b01, 32'hFFFFFFFD, 32'd5, lat, sok);
    check("b2b_second_latency", 64'(lat), 64'd18);
    check("b2b_second_hi", 64'(hi_v[0]), 64'hFFFFFFFF);
    check("b2b_second_lo", 64'(lo_v[0]), 64'hFFFFFFF1);
    go_idle();

    // MULTU 0xFFFFFFFF^2 on MUL_STEP 1, 4, 8 instances
    for (int s = 1; s < 4; s++) begin
      run_op(s, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, sok);
      check($sformatf("mulstep%0d_latency", s), 64'(lat), 64'(ms_lat[s-1]));
      check($sformatf("mulstep%0d_hi", s), 64'(hi_v[s]), 64'hFFFFFFFE);
      check($sformatf("mulstep%0d_lo", s), 64'(lo_v[s]), 64'h00000001);
      go_idle();
    end

    // Reset in mid-CALC clears outputs; unit then accepts normally
    @(negedge clk);
    op = 2'b10; a = 32'd100; b = 32'd7; start_v[0] = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("rst_mid_busy_before", 64'(busy_v[0]), 64'd1);
    rst = 1'b1; start_v[0] = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid_hi",    64'(hi_v[0]), 64'd0);
    check("rst_mid_lo",    64'(lo_v[0]), 64'd0);
    check("rst_mid_done",  64'(done_v[0]), 64'd0);
    check("rst_mid_busy",  64'(busy_v[0]), 64'd0);
    check("rst_mid_dbz",   64'(dbz_v[0]), 64'd0);
    check("rst_mid_stall", 64'(stall_v[0]), 64'd0);
    rst = 1'b0;
    run_op(0, 2'b10, 32'd100, 32'd7, lat, sok);
    check("post_rst_latency", 64'(lat), 64'd34);
    check("post_rst_lo", 64'(lo_v[0]), 64'h0000000E);
    go_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
